// File: rtl/hs4_pkg.sv
// hs4_pkg
// Shared types and limits for the four-phase source bridge.
//   hs4_state_e   : handshake FSM states (IDLE, SETUP, REQ_HI, REQ_LO)
//   HS4_SYNC_MIN  : fewest flops allowed in an acknowledge synchronizer
//   HS4_DEPTH_MIN : fewest FIFO entries allowed
package hs4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } hs4_state_e;

  localparam int HS4_SYNC_MIN  = 2;
  localparam int HS4_DEPTH_MIN = 2;

endpackage

// File: rtl/hs4_sync.sv
// hs4_sync
// Plain flop-chain synchronizer for one asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : synchronized level, STAGES edges behind d
module hs4_sync
  import hs4_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Refuse to build a chain too short to settle metastability.
  if (STAGES < HS4_SYNC_MIN) begin : g_bad_stages
    $error("hs4_sync: STAGES must be at least %0d", HS4_SYNC_MIN);
  end

  // Shift the input through the chain; the oldest stage is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_src_bridge.sv
// hs4_src_bridge
// Converts a clocked valid/ready stream into a four-phase (return-to-zero)
// bundled-data handshake toward an asynchronous fork. A small FIFO absorbs
// handshake latency; the acknowledge is synchronized before use.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   in_valid_i   : producer offers in_data_i
//   in_ready_o   : FIFO not full (from the registered full flag only)
//   in_data_i    : producer word
//   req_o        : registered four-phase request
//   ack_i        : asynchronous acknowledge from downstream
//   data_o       : registered bundled data, stable while the handshake is open
//   busy_o       : FIFO non-empty or FSM not idle
//   xfer_cnt_o   : completed handshakes, wraps modulo 2^CNT_W
module hs4_src_bridge
  import hs4_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              req_o,
  input  logic              ack_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  xfer_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  // Reject illegal configurations at elaboration.
  if ((SYNC_STAGES < HS4_SYNC_MIN) || (DEPTH < HS4_DEPTH_MIN) ||
      ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
    $error("hs4_src_bridge: illegal DEPTH=%0d or SYNC_STAGES=%0d", DEPTH, SYNC_STAGES);
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
  logic              empty_q, full_q;
  logic              push, pop;
  logic              ack_s;
  hs4_state_e        state_q, state_n;
  logic              req_q, req_n;
  logic              cnt_inc;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  hs4_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (ack_i),
    .q   (ack_s)
  );

  // A full FIFO blocks the push outright, even if the FSM pops this cycle,
  // so in_ready_o never depends on the handshake side.
  assign push       = in_valid_i && !full_q;
  assign in_ready_o = !full_q;

  assign wr_ptr_n = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_n = rd_ptr_q + {{AW{1'b0}}, pop};

  // Pointers carry one extra wrap bit; flags are computed from the next
  // pointer values and registered so downstream logic sees clean levels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      empty_q  <= (wr_ptr_n == rd_ptr_n);
      full_q   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                  (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= in_data_i;
    end
  end

  // Handshake sequencing. SETUP gives data one full cycle ahead of the
  // request; the return-to-zero phase waits for the synchronized ack to drop
  // before the next word may be loaded.
  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    pop     = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        req_n   = 1'b1;
        state_n = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          req_n   = 1'b0;
          cnt_inc = 1'b1;
          state_n = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          if (!empty_q) begin
            pop     = 1'b1;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, request, bundled data and transfer counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      if (pop) begin
        data_q <= mem[rd_ptr_q[AW-1:0]];
      end
      if (cnt_inc) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign req_o      = req_q;
  assign data_o     = data_q;
  assign xfer_cnt_o = cnt_q;
  assign busy_o     = !empty_q || (state_q != IDLE);

endmodule

// File: tb/tb_hs4_src_bridge.sv
// tb_hs4_src_bridge
// Self-checking bench for hs4_src_bridge, built with SYNC_STAGES=3 and
// CNT_W=4 so synchronizer latency and counter wrap are both exercised.
// Words pushed are queued as expectations; each req_o rise pops one and
// compares data_o. A bench-side downstream model answers req_o with a
// fixed or random delay.
module tb_hs4_src_bridge;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int SS = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          req;
  logic          ack;
  logic [DW-1:0] data;
  logic          busy;
  logic [CW-1:0] xfer_cnt;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] exp_cnt;

  bit ack_en    = 1'b0;
  bit rand_dly  = 1'b0;
  int fixed_dly = 0;
  int ack_wait  = 0;

  logic          req_prev, acks_prev;
  logic [DW-1:0] data_prev;

  hs4_src_bridge #(
    .DATA_W      (DW),
    .DEPTH       (DP),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .req_o      (req),
    .ack_i      (ack),
    .data_o     (data),
    .busy_o     (busy),
    .xfer_cnt_o (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Downstream model: ack follows req after a per-phase delay.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && !rst) begin
        if (ack == req) begin
          ack_wait = rand_dly ? int'($urandom_range(0, 20)) : fixed_dly;
        end else if (ack_wait == 0) begin
          ack = req;
        end else begin
          ack_wait--;
        end
      end
    end
  end

  // Scoreboard and stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (rst) begin
      req_prev  = 1'b0;
      acks_prev = 1'b0;
      data_prev = data;
    end else begin
      if (req_prev || acks_prev) begin
        check_cnt++;
        if (data !== data_prev) $display("[TB] FAIL data_stable: data_o=%h was %h", data, data_prev);
        else pass_cnt++;
      end
      if (req && !req_prev) begin
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_req: req_o rose with data_o=%h, nothing expected", data);
        end else begin
          exp_w = exp_q.pop_front();
          if (data !== exp_w) $display("[TB] FAIL data_order: data_o=%h expected %h", data, exp_w);
          else pass_cnt++;
        end
      end
      if (!req && req_prev) begin
        exp_cnt++;
        check_cnt++;
        if (xfer_cnt !== exp_cnt) $display("[TB] FAIL xfer_cnt_track: xfer_cnt_o=%0d expected %0d", xfer_cnt, exp_cnt);
        else pass_cnt++;
      end
      req_prev  = req;
      acks_prev = dut.ack_s;
      data_prev = data;
    end
  end

  // Push one word, waiting (bounded) for space; records the expectation.
  task automatic applyStimulus(input logic [DW-1:0] word, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready) begin
      @(posedge clk);
      exp_q.push_back(word);
      ok = 1'b1;
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!busy && !req && !ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input logic val, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (req === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    check_cnt++; if (req !== 1'b0) $display("[TB] FAIL rst_req: req_o=%b expected 0", req); else pass_cnt++;
    check_cnt++; if (data !== '0) $display("[TB] FAIL rst_data: data_o=%h expected 0", data); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== '0) $display("[TB] FAIL rst_cnt: xfer_cnt_o=%0d expected 0", xfer_cnt); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_ready: in_ready_o=%b expected 1", in_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: busy_o=%b expected 0", busy); else pass_cnt++;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    ack_en = 1'b1; rand_dly = 1'b0; fixed_dly = 0;
    applyStimulus(32'hA5A5_0001, ok);
    @(negedge clk);
    check_cnt++; if (req !== 1'b0) $display("[TB] FAIL single_req_t0: req_o=%b expected 0", req); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    check_cnt++; if (req !== 1'b0) $display("[TB] FAIL single_req_t1: req_o=%b expected 0", req); else pass_cnt++;
    check_cnt++; if (data !== 32'hA5A5_0001) $display("[TB] FAIL single_data_t1: data_o=%h expected a5a50001", data); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    check_cnt++; if (req !== 1'b1) $display("[TB] FAIL single_req_t2: req_o=%b expected 1", req); else pass_cnt++;
    wait_idle(200, ok);
    check_cnt++; if (!ok) $display("[TB] FAIL single_idle: busy_o=%b req_o=%b, expected idle", busy, req); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== 4'd1) $display("[TB] FAIL single_cnt: xfer_cnt_o=%0d expected 1", xfer_cnt); else pass_cnt++;
  endtask

  task automatic test_fill_order();
    bit ok, all_ok;
    ack_en = 1'b0; ack = 1'b0;
    all_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(DW'(i), ok);
      all_ok &= ok;
    end
    @(negedge clk);
    check_cnt++; if (!all_ok) $display("[TB] FAIL fill_push: push timed out, ok=%b expected 1", all_ok); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL fill_ready: in_ready_o=%b expected 0", in_ready); else pass_cnt++;
    check_cnt++; if (req !== 1'b1) $display("[TB] FAIL fill_req: req_o=%b expected 1", req); else pass_cnt++;
    check_cnt++; if (data !== 32'd1) $display("[TB] FAIL fill_head: data_o=%h expected 1", data); else pass_cnt++;
    ack_en = 1'b1; fixed_dly = 0;
    applyStimulus(32'd6, ok);
    wait_idle(1000, ok);
    check_cnt++; if (!ok) $display("[TB] FAIL fill_idle: busy_o=%b req_o=%b, expected idle", busy, req); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== 4'd7) $display("[TB] FAIL fill_cnt: xfer_cnt_o=%0d expected 7", xfer_cnt); else pass_cnt++;
    check_cnt++; if (exp_q.size() != 0) $display("[TB] FAIL fill_drain: %0d words left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_data_stability();
    bit ok, all_ok;
    ack_en = 1'b1; rand_dly = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus({8'(i), 24'($urandom)}, ok);
      all_ok &= ok;
    end
    wait_idle(20000, ok);
    rand_dly = 1'b0;
    check_cnt++; if (!all_ok) $display("[TB] FAIL stab_push: push timed out, ok=%b expected 1", all_ok); else pass_cnt++;
    check_cnt++; if (!ok) $display("[TB] FAIL stab_idle: busy_o=%b req_o=%b, expected idle", busy, req); else pass_cnt++;
    check_cnt++; if (exp_q.size() != 0) $display("[TB] FAIL stab_drain: %0d words left expected 0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== 4'd15) $display("[TB] FAIL stab_cnt: xfer_cnt_o=%0d expected 15", xfer_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_handshake();
    bit ok, saw_req;
    ack_en = 1'b0; ack = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(32'hBEEF_0000 + DW'(i), ok);
    wait_req(1'b1, 50, ok);
    check_cnt++; if (!ok) $display("[TB] FAIL mid_reqhi: req_o=%b expected 1", req); else pass_cnt++;
    #2 rst = 1'b1;
    ack = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    #1;
    check_cnt++; if (req !== 1'b0) $display("[TB] FAIL mid_req: req_o=%b expected 0", req); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_ready: in_ready_o=%b expected 1", in_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy: busy_o=%b expected 0", busy); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== '0) $display("[TB] FAIL mid_cnt: xfer_cnt_o=%0d expected 0", xfer_cnt); else pass_cnt++;
    @(posedge clk); @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      saw_req |= req;
    end
    check_cnt++; if (saw_req !== 1'b0) $display("[TB] FAIL mid_noreq: req_o seen=%b expected 0", saw_req); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL mid_flush: busy_o=%b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    bit ok, all_ok;
    ack_en = 1'b1; fixed_dly = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(32'h0000_0100 * DW'(i + 1), ok);
      all_ok &= ok;
    end
    wait_idle(2000, ok);
    check_cnt++; if (!(all_ok && ok)) $display("[TB] FAIL wrap_idle: push ok=%b idle ok=%b expected 1", all_ok, ok); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== 4'd1) $display("[TB] FAIL wrap_cnt: xfer_cnt_o=%0d expected 1", xfer_cnt); else pass_cnt++;
  endtask

  task automatic test_sync_latency();
    bit ok;
    logic exp_req;
    ack_en = 1'b0; ack = 1'b0;
    applyStimulus(32'hCAFE_0001, ok);
    applyStimulus(32'hCAFE_0002, ok);
    wait_req(1'b1, 50, ok);
    check_cnt++; if (!ok) $display("[TB] FAIL lat_reqhi: req_o=%b expected 1", req); else pass_cnt++;
    @(posedge clk); #1 ack = 1'b1;
    for (int j = 1; j <= SS + 1; j++) begin
      @(posedge clk); @(negedge clk);
      exp_req = (j <= SS);
      check_cnt++;
      if (req !== exp_req) $display("[TB] FAIL lat_fall_k%0d: req_o=%b expected %b", j, req, exp_req);
      else pass_cnt++;
    end
    @(posedge clk); #1 ack = 1'b0;
    for (int j = 1; j <= SS + 2; j++) begin
      @(posedge clk); @(negedge clk);
      exp_req = (j == SS + 2);
      check_cnt++;
      if (req !== exp_req) $display("[TB] FAIL lat_rise_m%0d: req_o=%b expected %b", j, req, exp_req);
      else pass_cnt++;
    end
    @(posedge clk); #1 ack = 1'b1;
    wait_req(1'b0, 50, ok);
    @(posedge clk); #1 ack = 1'b0;
    wait_idle(100, ok);
    check_cnt++; if (!ok) $display("[TB] FAIL lat_idle: busy_o=%b req_o=%b, expected idle", busy, req); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== 4'd3) $display("[TB] FAIL lat_cnt: xfer_cnt_o=%0d expected 3", xfer_cnt); else pass_cnt++;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ack      = 1'b0;
    exp_cnt  = '0;
    test_reset();
    test_single();
    test_fill_order();
    test_data_stability();
    test_reset_mid_handshake();
    test_counter_wrap();
    test_sync_latency();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
